// File: rtl/sd_sector_arbiter.sv
// rtl/sd_sector_arbiter.sv - round-robin arbiter sharing the user_io SD sector channel
module sd_sector_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 32_000_000
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_rd,
    input  logic [NREQ-1:0]   req_wr,
    input  logic [NREQ*32-1:0] req_lba,
    input  logic [NREQ*8-1:0] req_buff_din,
    output logic [NREQ-1:0]   req_buff_wr,
    output logic [NREQ-1:0]   req_done,
    output logic [NREQ-1:0]   req_err,
    output logic              busy,
    output logic [1:0]        grant,
    output logic [31:0]       sd_lba,
    output logic              sd_rd,
    output logic              sd_wr,
    input  logic              sd_ack,
    input  logic              sd_buff_wr,
    input  logic [7:0]        sd_buff_dout,
    output logic [7:0]        sd_buff_din
);

    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

    state_t          state, state_nxt;
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] grant_oh;
    logic            found;
    logic [1:0]      pick;
    logic [31:0]     lba_sel;
    logic            rd_sel;
    logic            op_read;
    logic            err_flag;
    logic [WDW-1:0]  wdog;
    logic            wd_expired;
    int              idx;

    // sd_buff_dout goes to the requesters externally; this block never looks at it
    logic            dout_unused;
    assign dout_unused = ^sd_buff_dout;

    assign pending    = req_rd | req_wr;
    assign busy       = (state != IDLE);
    assign wd_expired = (wdog == WD_LAST);

    // Round-robin search: first pending index upward from grant+1, wrapping at NREQ
    always_comb begin
        found = 1'b0;
        pick  = grant;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(grant) + k) % NREQ;
            if (!found && pending[idx]) begin
                found = 1'b1;
                pick  = 2'(idx);
            end
        end
    end

    // Per-requester selection muxes for the candidate pick and the current grant
    always_comb begin
        lba_sel     = '0;
        rd_sel      = 1'b0;
        sd_buff_din = '0;
        grant_oh    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == 2'(i)) begin
                lba_sel = req_lba[i*32 +: 32];
                rd_sel  = req_rd[i];
            end
            if (grant == 2'(i)) begin
                sd_buff_din = req_buff_din[i*8 +: 8];
                grant_oh[i] = 1'b1;
            end
        end
    end

    // Buffer strobes reach only the granted requester, and only in the data phase
    always_comb begin
        req_buff_wr = '0;
        if (state == XFER && sd_buff_wr) begin
            req_buff_wr = grant_oh;
        end
    end

    // Next-state logic for the transfer sequencer
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (found) state_nxt = ISSUE;
            ISSUE: begin
                if (sd_ack) begin
                    state_nxt = XFER;
                end else if (wd_expired) begin
                    state_nxt = DONE;
                end
            end
            XFER:  if (!sd_ack) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, latched transfer, watchdog and registered request/completion outputs
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant    <= 2'(NREQ - 1);
            sd_lba   <= '0;
            op_read  <= 1'b0;
            sd_rd    <= 1'b0;
            sd_wr    <= 1'b0;
            wdog     <= '0;
            err_flag <= 1'b0;
            req_done <= '0;
            req_err  <= '0;
        end else begin
            state    <= state_nxt;
            req_done <= '0;
            req_err  <= '0;
            case (state)
                IDLE: begin
                    wdog <= '0;
                    if (found) begin
                        grant   <= pick;
                        sd_lba  <= lba_sel;
                        op_read <= rd_sel;
                    end
                end
                ISSUE: begin
                    if (sd_ack) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        wdog  <= '0;
                    end else if (wd_expired) begin
                        sd_rd    <= 1'b0;
                        sd_wr    <= 1'b0;
                        err_flag <= 1'b1;
                    end else begin
                        sd_rd <= op_read;
                        sd_wr <= ~op_read;
                        if (wdog != '1) begin
                            wdog <= wdog + 1'b1;
                        end
                    end
                end
                DONE: begin
                    req_done <= grant_oh;
                    req_err  <= err_flag ? grant_oh : '0;
                    err_flag <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// tb/tb_sd_sector_arbiter.sv - scoreboard testbench for sd_sector_arbiter
module tb_sd_sector_arbiter;

    localparam int NREQ = 2;

    typedef struct packed {
        logic [1:0]  g;
        logic [31:0] lba;
        logic        rd;
    } issue_t;

    typedef struct packed {
        logic [1:0] oh;
        logic [1:0] err;
    } done_t;

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic [NREQ-1:0]   req_rd;
    logic [NREQ-1:0]   req_wr;
    logic [NREQ*32-1:0] req_lba;
    logic [NREQ*8-1:0] req_buff_din;
    logic [NREQ-1:0]   req_buff_wr;
    logic [NREQ-1:0]   req_done;
    logic [NREQ-1:0]   req_err;
    logic              busy;
    logic [1:0]        grant;
    logic [31:0]       sd_lba;
    logic              sd_rd;
    logic              sd_wr;
    logic              sd_ack;
    logic              sd_buff_wr;
    logic [7:0]        sd_buff_dout;
    logic [7:0]        sd_buff_din;

    int n_tests = 0;
    int n_fail  = 0;

    issue_t exp_issue[$];
    done_t  exp_done[$];

    int  cyc = 0;
    int  busy_cyc = 0;
    int  issue_len = 0;
    int  cnt0 = 0;
    int  cnt1 = 0;
    int  din_bad = 0;
    logic chk_din = 1'b0;
    logic busy_q = 1'b0;
    logic act_q = 1'b0;

    always #5 clk_sys = ~clk_sys;

    sd_sector_arbiter #(.NREQ(NREQ), .TIMEOUT(100)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_lba      (req_lba),
        .req_buff_din (req_buff_din),
        .req_buff_wr  (req_buff_wr),
        .req_done     (req_done),
        .req_err      (req_err),
        .busy         (busy),
        .grant        (grant),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_din  (sd_buff_din)
    );

    task automatic tb_check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each issue and each completion pulse
    always @(negedge clk_sys) begin
        issue_t ei;
        done_t  ed;
        cyc++;
        if (busy && !busy_q) busy_cyc = cyc;
        if (!(sd_rd | sd_wr) && act_q) issue_len = cyc - busy_cyc;
        if ((sd_rd | sd_wr) && !act_q) begin
            if (exp_issue.size() == 0) begin
                tb_check("issue_unexpected", 32'(grant), 32'hFFFF_FFFF);
            end else begin
                ei = exp_issue.pop_front();
                tb_check("issue_grant", 32'(grant), 32'(ei.g));
                tb_check("issue_lba", sd_lba, ei.lba);
                tb_check("issue_rd", 32'(sd_rd), 32'(ei.rd));
                tb_check("issue_wr", 32'(sd_wr), 32'(!ei.rd));
            end
        end
        if (req_done != '0) begin
            if (exp_done.size() == 0) begin
                tb_check("done_unexpected", 32'(req_done), 32'h0);
            end else begin
                ed = exp_done.pop_front();
                tb_check("done_idx", 32'(req_done), 32'(ed.oh));
                tb_check("done_err", 32'(req_err), 32'(ed.err));
            end
        end
        if (req_buff_wr[0]) cnt0++;
        if (req_buff_wr[1]) cnt1++;
        if (chk_din && req_buff_wr != '0 && sd_buff_din != 8'hA5) din_bad++;
        busy_q = busy;
        act_q  = sd_rd | sd_wr;
    end

    // SD model: wait for a request, raise ack, emit strobes, optionally end the data phase
    task automatic sd_serve(input int n, input bit drop);
        bit seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk_sys); #1;
            if (sd_rd | sd_wr) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            tb_check("serve_wait", 32'h0, 32'h1);
            return;
        end
        sd_ack = 1'b1;
        @(posedge clk_sys); #1;
        for (int k = 0; k < n; k++) begin
            sd_buff_wr = 1'b1;
            @(posedge clk_sys); #1;
            sd_buff_wr = 1'b0;
            @(posedge clk_sys); #1;
        end
        if (drop) sd_ack = 1'b0;
    endtask

    // Requester side: wait for its done pulse, drop the request, check pulse width
    task automatic wait_done(input int i, input int bound, input bit rearm);
        bit got = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(posedge clk_sys); #1;
            if (req_done[i]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            tb_check("done_wait", 32'h0, 32'h1);
            return;
        end
        req_rd[i] = 1'b0;
        req_wr[i] = 1'b0;
        @(posedge clk_sys); #1;
        tb_check("done_width", 32'(req_done), 32'h0);
        if (rearm) req_rd[i] = 1'b1;
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int b0, b1, db;
        reset_n = 1'b0;
        req_rd = '0;
        req_wr = '0;
        req_lba = '0;
        req_buff_din = '0;
        sd_ack = 1'b0;
        sd_buff_wr = 1'b0;
        sd_buff_dout = 8'h5A;
        repeat (2) @(posedge clk_sys);
        #1;
        tb_check("rst_busy", 32'(busy), 32'h0);
        tb_check("rst_grant", 32'(grant), 32'h1);
        tb_check("rst_lba", sd_lba, 32'h0);
        tb_check("rst_rdwr", 32'({sd_rd, sd_wr}), 32'h0);
        tb_check("rst_done", 32'({req_done, req_err}), 32'h0);
        tb_check("rst_strobe", 32'(req_buff_wr), 32'h0);

        // Round-robin from reset: both requesters keep re-requesting
        req_lba = {32'h0000_0200, 32'h0000_0100};
        for (int r = 0; r < 4; r++) begin
            exp_issue.push_back('{g: 2'(r % 2), lba: (r % 2) ? 32'h200 : 32'h100, rd: 1'b1});
            exp_done.push_back('{oh: (r % 2) ? 2'b10 : 2'b01, err: 2'b00});
        end
        req_rd = 2'b11;
        reset_n = 1'b1;
        for (int r = 0; r < 4; r++) begin
            sd_serve(4, 1'b1);
            wait_done(r % 2, 40, r < 2);
        end

        // Single read with full 512-strobe data phase
        req_lba[31:0] = 32'h0000_0123;
        b0 = cnt0;
        b1 = cnt1;
        exp_issue.push_back('{g: 2'd0, lba: 32'h123, rd: 1'b1});
        exp_done.push_back('{oh: 2'b01, err: 2'b00});
        req_rd[0] = 1'b1;
        @(posedge clk_sys); #1;
        tb_check("lat_issue_busy", 32'({busy, sd_rd}), 32'h2);
        @(posedge clk_sys); #1;
        tb_check("lat_rd", 32'({sd_rd, sd_wr}), 32'h2);
        tb_check("lat_lba", sd_lba, 32'h123);
        sd_serve(512, 1'b1);
        wait_done(0, 40, 1'b0);
        tb_check("strobes_req0", 32'(cnt0 - b0), 32'd512);
        tb_check("strobes_req1", 32'(cnt1 - b1), 32'd0);

        // Read and write asserted together: read wins
        req_lba[31:0] = 32'h0000_0077;
        exp_issue.push_back('{g: 2'd0, lba: 32'h77, rd: 1'b1});
        exp_done.push_back('{oh: 2'b01, err: 2'b00});
        req_rd[0] = 1'b1;
        req_wr[0] = 1'b1;
        sd_serve(2, 1'b1);
        wait_done(0, 40, 1'b0);

        // Write from requester 1: data mux must follow the grant
        req_lba[63:32] = 32'h0000_0456;
        req_buff_din = {8'hA5, 8'h3C};
        b1 = cnt1;
        db = din_bad;
        exp_issue.push_back('{g: 2'd1, lba: 32'h456, rd: 1'b0});
        exp_done.push_back('{oh: 2'b10, err: 2'b00});
        chk_din = 1'b1;
        req_wr[1] = 1'b1;
        sd_serve(16, 1'b1);
        wait_done(1, 40, 1'b0);
        chk_din = 1'b0;
        tb_check("wr_din_bad", 32'(din_bad - db), 32'd0);
        tb_check("wr_strobes", 32'(cnt1 - b1), 32'd16);

        // Timeout on requester 0, then requester 1 gets served
        req_lba = {32'h0000_0901, 32'h0000_0900};
        exp_issue.push_back('{g: 2'd0, lba: 32'h900, rd: 1'b1});
        exp_issue.push_back('{g: 2'd1, lba: 32'h901, rd: 1'b0});
        exp_done.push_back('{oh: 2'b01, err: 2'b01});
        exp_done.push_back('{oh: 2'b10, err: 2'b00});
        req_rd[0] = 1'b1;
        req_wr[1] = 1'b1;
        wait_done(0, 300, 1'b0);
        tb_check("timeout_len", 32'(issue_len), 32'd100);
        sd_serve(2, 1'b1);
        wait_done(1, 40, 1'b0);

        // Reset in the middle of the data phase
        req_lba[31:0] = 32'h0000_0ABC;
        exp_issue.push_back('{g: 2'd0, lba: 32'hABC, rd: 1'b1});
        req_rd[0] = 1'b1;
        sd_serve(200, 1'b0);
        sd_buff_wr = 1'b1;
        reset_n = 1'b0;
        #1;
        tb_check("mid_rst_busy", 32'(busy), 32'h0);
        tb_check("mid_rst_rdwr", 32'({sd_rd, sd_wr}), 32'h0);
        tb_check("mid_rst_lba", sd_lba, 32'h0);
        tb_check("mid_rst_strobe", 32'(req_buff_wr), 32'h0);
        tb_check("mid_rst_grant", 32'(grant), 32'h1);
        sd_buff_wr = 1'b0;
        sd_ack = 1'b0;
        req_rd = '0;
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        repeat (6) @(posedge clk_sys);
        #1;
        tb_check("post_rst_done", 32'(req_done), 32'h0);
        req_lba[31:0] = 32'h0000_0DEF;
        exp_issue.push_back('{g: 2'd0, lba: 32'hDEF, rd: 1'b1});
        exp_done.push_back('{oh: 2'b01, err: 2'b00});
        req_rd[0] = 1'b1;
        sd_serve(2, 1'b1);
        wait_done(0, 40, 1'b0);

        repeat (4) @(posedge clk_sys);
        #1;
        tb_check("issue_q_empty", 32'(exp_issue.size()), 32'd0);
        tb_check("done_q_empty", 32'(exp_done.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
